// File: rtl/regfile_ic_pkg.sv
// Shared checkpoint definitions: FSM state encoding and per-register dirty field layout.
// No logic, so no latency and no backpressure of its own.
package regfile_ic_pkg;

    localparam int DIRTY_W = 2;
    localparam logic [DIRTY_W-1:0] DIRTY_CLEAN = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_B_SCAN  = 3'd1,
        ST_B_WRITE = 3'd2,
        ST_B_ACK   = 3'd3,
        ST_R_READ  = 3'd4,
        ST_R_LOAD  = 3'd5,
        ST_DONE    = 3'd6
    } ckpt_state_t;

    function automatic logic is_dirty(input logic [DIRTY_W-1:0] v);
        return v != DIRTY_CLEAN;
    endfunction

endpackage

// File: rtl/regfile_ic_ckpt_ctrl_dec.sv
// Gated one-hot decoder of the register index; purely combinational, zero latency.
// No backpressure: the output is all-zero whenever en is low.
module regfile_ic_ckpt_ctrl_dec #(
    parameter int AW = 5,
    parameter int M  = 32
) (
    input  logic [AW-1:0] idx,
    input  logic          en,
    output logic [M-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < M; i++) begin
            if (en && (idx == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_ic_ckpt_ctrl.sv
// Register-file checkpoint controller: backs up dirty registers to NVM, restores all words.
// Backup M+2D+1 / restore 2M+1 cycles with NVM ready; every NVM access stalls until Nvm_ready.
module regfile_ic_ckpt_ctrl
    import regfile_ic_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 32,
    localparam int AW = $clog2(M)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Backup_req,
    input  logic             Restore_req,
    output logic             Busy,
    output logic             Done,
    input  logic [2*M-1:0]   Dirty_vals,
    output logic [M-1:0]     Backup_ens,
    output logic [M-1:0]     Backup_acks,
    input  logic [M*N-1:0]   Backup_Vouts,
    output logic [M-1:0]     Restore_ens,
    output logic [M*N-1:0]   Restore_Vins,
    output logic [AW-1:0]    Nvm_addr,
    output logic [N-1:0]     Nvm_wdata,
    output logic             Nvm_we,
    output logic             Nvm_re,
    input  logic [N-1:0]     Nvm_rdata,
    input  logic             Nvm_ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

    ckpt_state_t      state;
    logic [AW-1:0]    idx;
    logic [N-1:0]     rdata_q;
    logic             last;
    logic [DIRTY_W-1:0] cur_dirty;
    logic [N-1:0]     cur_vout;

    assign last      = (idx == LAST_IDX);
    assign cur_dirty = Dirty_vals[{idx, 1'b0} +: DIRTY_W];
    assign cur_vout  = Backup_Vouts[int'(idx) * N +: N];

    // idx only advances on non-final registers, so it saturates at M-1 without wrapping.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Restore_req) begin
                        state <= ST_R_READ;
                        idx   <= '0;
                    end else if (Backup_req) begin
                        state <= ST_B_SCAN;
                        idx   <= '0;
                    end
                end
                ST_B_SCAN: begin
                    if (is_dirty(cur_dirty)) begin
                        state <= ST_B_WRITE;
                    end else if (last) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_B_WRITE: begin
                    if (Nvm_ready) begin
                        state <= ST_B_ACK;
                    end
                end
                ST_B_ACK: begin
                    if (last) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= ST_B_SCAN;
                    end
                end
                ST_R_READ: begin
                    if (Nvm_ready) begin
                        rdata_q <= Nvm_rdata;
                        state   <= ST_R_LOAD;
                    end
                end
                ST_R_LOAD: begin
                    if (last) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= ST_R_READ;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy         = (state != ST_IDLE);
    assign Done         = (state == ST_DONE);
    assign Nvm_we       = (state == ST_B_WRITE);
    assign Nvm_re       = (state == ST_R_READ);
    assign Nvm_addr     = idx;
    assign Nvm_wdata    = Nvm_we ? cur_vout : '0;
    assign Restore_Vins = {M{rdata_q}};

    regfile_ic_ckpt_ctrl_dec #(.AW(AW), .M(M)) u_dec_ben (
        .idx    (idx),
        .en     (state == ST_B_WRITE),
        .onehot (Backup_ens)
    );

    regfile_ic_ckpt_ctrl_dec #(.AW(AW), .M(M)) u_dec_back (
        .idx    (idx),
        .en     (state == ST_B_ACK),
        .onehot (Backup_acks)
    );

    regfile_ic_ckpt_ctrl_dec #(.AW(AW), .M(M)) u_dec_ren (
        .idx    (idx),
        .en     (state == ST_R_LOAD),
        .onehot (Restore_ens)
    );

endmodule

// File: tb/tb_regfile_ic_ckpt_ctrl.sv
// Bench: acts as register file and NVM around the checkpoint controller, checks against a behavioural model.
module tb_regfile_ic_ckpt_ctrl;

    localparam int N  = 32;
    localparam int M  = 32;
    localparam int AW = 5;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Backup_req = 1'b0;
    logic             Restore_req = 1'b0;
    logic             Busy, Done;
    logic [2*M-1:0]   Dirty_vals = '0;
    logic [M-1:0]     Backup_ens, Backup_acks, Restore_ens;
    logic [M*N-1:0]   Backup_Vouts = '0;
    logic [M*N-1:0]   Restore_Vins;
    logic [AW-1:0]    Nvm_addr;
    logic [N-1:0]     Nvm_wdata;
    logic             Nvm_we, Nvm_re;
    logic [N-1:0]     Nvm_rdata = '0;
    logic             Nvm_ready = 1'b0;

    always #5 Clk = ~Clk;

    regfile_ic_ckpt_ctrl #(.N(N), .M(M)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Backup_req   (Backup_req),
        .Restore_req  (Restore_req),
        .Busy         (Busy),
        .Done         (Done),
        .Dirty_vals   (Dirty_vals),
        .Backup_ens   (Backup_ens),
        .Backup_acks  (Backup_acks),
        .Backup_Vouts (Backup_Vouts),
        .Restore_ens  (Restore_ens),
        .Restore_Vins (Restore_Vins),
        .Nvm_addr     (Nvm_addr),
        .Nvm_wdata    (Nvm_wdata),
        .Nvm_we       (Nvm_we),
        .Nvm_re       (Nvm_re),
        .Nvm_rdata    (Nvm_rdata),
        .Nvm_ready    (Nvm_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] regs [M];
    logic [N-1:0] nvm  [M];
    logic [1:0]   code [M];
    bit           dirty [M];
    int           ack_cnt [M];
    int           ready_dly = 0;
    int           wcnt = 0;
    int           stall_addr = -1;
    bit           we_seen, be_seen;
    int           wr_addr_q [$];
    logic [N-1:0] wr_data_q [$];
    int           ack_q [$];
    int           load_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < M; i++) begin
            Dirty_vals[2*i +: 2]   = dirty[i] ? code[i] : 2'b00;
            Backup_Vouts[i*N +: N] = regs[i];
        end
    endtask

    // Register-file and NVM behaviour for the cycle just entered.
    task automatic observe();
        logic [M-1:0] sel;
        bit ok;
        sel = '0;
        sel[Nvm_addr] = 1'b1;
        ok = $onehot0(Backup_ens) && $onehot0(Backup_acks) && $onehot0(Restore_ens)
             && !(Nvm_we && Nvm_re) && (!Nvm_we || (Backup_ens == sel));
        check("strobe_rules", ok, 1);
        if (Backup_ens != '0) be_seen = 1;
        if (Nvm_we) we_seen = 1;
        for (int i = 0; i < M; i++) begin
            if (Backup_acks[i]) begin
                dirty[i] = 0;
                ack_cnt[i]++;
                ack_q.push_back(i);
            end
            if (Restore_ens[i]) begin
                regs[i] = Restore_Vins[i*N +: N];
                load_q.push_back(i);
            end
        end
        if ((Nvm_we || Nvm_re) && !(Nvm_we && int'(Nvm_addr) == stall_addr)) begin
            if (wcnt >= ready_dly) begin
                Nvm_ready = 1'b1;
                wcnt = 0;
                if (Nvm_we) begin
                    nvm[Nvm_addr] = Nvm_wdata;
                    wr_addr_q.push_back(int'(Nvm_addr));
                    wr_data_q.push_back(Nvm_wdata);
                end else begin
                    Nvm_rdata = nvm[Nvm_addr];
                end
            end else begin
                Nvm_ready = 1'b0;
                wcnt++;
            end
        end else begin
            Nvm_ready = 1'b0;
            wcnt = 0;
        end
        drive_inputs();
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        observe();
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        ack_q.delete();
        load_q.delete();
        we_seen = 0;
        be_seen = 0;
    endtask

    // Request cycle is cycle 0; lat is the cycle index in which Done is seen.
    task automatic run_op(input bit bk, input bit rs, input int poke, output int lat);
        Backup_req  = bk;
        Restore_req = rs;
        cyc();
        Backup_req  = 1'b0;
        Restore_req = 1'b0;
        lat = 1;
        while (!Done && lat < 5000) begin
            Backup_req = (lat == poke);
            cyc();
            lat++;
        end
        Backup_req = 1'b0;
        check("done_reached", Done, 1);
        cyc();
        check("done_one_cycle", {Done, Busy}, 0);
    endtask

    task automatic do_backup(input string tag);
        int exp_a [$];
        logic [N-1:0] exp_d [$];
        int lat, bad, left;
        for (int i = 0; i < M; i++) begin
            if (dirty[i]) begin
                exp_a.push_back(i);
                exp_d.push_back(regs[i]);
            end
        end
        clear_logs();
        run_op(1, 0, -1, lat);
        if (ready_dly == 0) check({tag, "_latency"}, lat, M + 2 * exp_a.size() + 1);
        check({tag, "_wr_count"}, wr_addr_q.size(), exp_a.size());
        check({tag, "_ack_count"}, ack_q.size(), exp_a.size());
        bad = 0;
        for (int k = 0; k < exp_a.size() && k < wr_addr_q.size() && k < ack_q.size(); k++) begin
            if (wr_addr_q[k] != exp_a[k] || wr_data_q[k] !== exp_d[k] || ack_q[k] != exp_a[k]) bad++;
        end
        check({tag, "_wr_order_data"}, bad, 0);
        left = 0;
        for (int i = 0; i < M; i++) if (dirty[i]) left++;
        check({tag, "_dirty_left"}, left, 0);
    endtask

    task automatic do_restore(input string tag);
        int lat, bad;
        clear_logs();
        for (int i = 0; i < M; i++) regs[i] = $urandom;
        drive_inputs();
        run_op(0, 1, -1, lat);
        if (ready_dly == 0) check({tag, "_latency"}, lat, 2 * M + 1);
        check({tag, "_load_count"}, load_q.size(), M);
        bad = 0;
        for (int i = 0; i < M; i++) begin
            if (i < load_q.size() && load_q[i] != i) bad++;
            if (regs[i] !== nvm[i]) bad++;
        end
        check({tag, "_load_order_data"}, bad, 0);
    endtask

    initial begin
        int lat, d, t;
        logic any;
        for (int i = 0; i < M; i++) begin
            regs[i] = $urandom;
            nvm[i] = '0;
            code[i] = 2'b01;
            dirty[i] = 0;
            ack_cnt[i] = 0;
        end
        drive_inputs();

        // Reset state and release
        #12;
        any = Busy | Done | (|Backup_ens) | (|Backup_acks) | (|Restore_ens) | (|Restore_Vins)
              | (|Nvm_addr) | (|Nvm_wdata) | Nvm_we | Nvm_re;
        check("reset_outputs", any, 0);
        Rst = 1'b1;
        cyc();
        check("idle_after_reset", Busy, 0);

        // All clean backup
        ready_dly = 0;
        do_backup("clean");
        check("clean_no_ens", be_seen, 0);
        check("clean_no_we", we_seen, 0);

        // Only reg 5 dirty
        regs[5] = 32'hDEADBEEF;
        dirty[5] = 1;
        code[5] = 2'b10;
        drive_inputs();
        do_backup("reg5");
        check("reg5_nvm", nvm[5], 32'hDEADBEEF);
        check("reg5_ack_once", ack_cnt[5], 1);

        // Restore with slow NVM
        for (int i = 0; i < M; i++) nvm[i] = 32'hA000_0000 + i;
        ready_dly = 3;
        do_restore("restore_slow");

        // Both requests: restore wins, a Backup_req while busy is dropped
        ready_dly = 0;
        dirty[2] = 1;
        dirty[20] = 1;
        drive_inputs();
        clear_logs();
        run_op(1, 1, 10, lat);
        check("prio_restore_loads", load_q.size(), M);
        check("prio_no_writes", wr_addr_q.size(), 0);
        cyc();
        cyc();
        check("dropped_req_idle", Busy, 0);
        check("dropped_req_dirty", {dirty[2], dirty[20]}, 2'b11);

        // Reset while writing reg 7
        for (int i = 0; i < M; i++) dirty[i] = 0;
        dirty[3] = 1;
        dirty[7] = 1;
        dirty[9] = 1;
        for (int i = 0; i < M; i++) begin
            regs[i] = $urandom;
            ack_cnt[i] = 0;
        end
        drive_inputs();
        stall_addr = 7;
        Backup_req = 1'b1;
        cyc();
        Backup_req = 1'b0;
        t = 0;
        while (Backup_ens != (32'd1 << 7) && t < 500) begin
            cyc();
            t++;
        end
        check("stall_on_reg7", Backup_ens, 32'd1 << 7);
        cyc();
        cyc();
        #2;
        Rst = 1'b0;
        #1;
        any = Busy | Done | (|Backup_ens) | (|Backup_acks) | (|Restore_ens) | (|Restore_Vins)
              | (|Nvm_addr) | (|Nvm_wdata) | Nvm_we | Nvm_re;
        check("async_reset_outputs", any, 0);
        Rst = 1'b1;
        stall_addr = -1;
        cyc();
        check("reg7_no_ack", ack_cnt[7], 0);
        check("reg7_still_dirty", dirty[7], 1);
        check("reg3_acked", {ack_cnt[3] == 1, dirty[3]}, 2'b10);
        do_backup("rerun");
        check("reg7_written", nvm[7], regs[7]);
        check("reg7_acked", ack_cnt[7], 1);

        // Randomised backup/restore rounds
        for (int r = 0; r < 6; r++) begin
            d = 0;
            for (int i = 0; i < M; i++) begin
                regs[i] = $urandom;
                dirty[i] = ($urandom_range(0, 2) == 0);
                code[i] = 2'($urandom_range(1, 3));
            end
            drive_inputs();
            ready_dly = $urandom_range(0, 2);
            do_backup("rand_backup");
            ready_dly = $urandom_range(0, 2);
            do_restore("rand_restore");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
